// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage IEEE-754 add/sub with valid/ready backpressure; FP_ADDSUB_RNE_EN selects RNE, otherwise truncation
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  input  logic             i_sub,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_vld,
  output logic             o_rdy,
  output logic [W-1:0]     o_res,
  output logic [TAG_W-1:0] o_tag,
  output logic [3:0]       o_flags,
  output logic             o_res_vld,
  input  logic             i_rdy
);
  localparam int GW = MAN_W + 4;
  localparam int SW = $clog2(MAN_W + 5);
  localparam int XW = (EXP_W > SW ? EXP_W : SW) + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  logic adv;
  logic sa, sb, swap, a_nan, b_nan, a_inf, b_inf, spc, spc_inv;
  logic [EXP_W-1:0] ea, eb, ea1, eb1, el, d;
  logic [MAN_W-1:0] ma, mb;
  logic [GW-1:0] gl, gx, gs, gmask;
  logic [W-1:0] spc_res;
  logic s1_vld, s1_sgn, s1_sub, s1_spc, s1_spc_inv;
  logic [EXP_W-1:0] s1_exp;
  logic [GW-1:0] s1_gl, s1_gs;
  logic [W-1:0] s1_spc_res;
  logic [TAG_W-1:0] s1_tag;
  logic s2_vld, s2_sgn, s2_sub, s2_spc, s2_spc_inv;
  logic [EXP_W-1:0] s2_exp;
  logic [GW:0] s2_sum;
  logic [W-1:0] s2_spc_res;
  logic [TAG_W-1:0] s2_tag;
  logic [SW-1:0] lz;
  logic [XW-1:0] e, sh, en, ef;
  logic [GW-1:0] n;
  logic [MAN_W+1:0] rnd;
  logic inc, tiny, inx, ovf, zs;
  logic [W-1:0] ovf_res, res;
  logic [3:0] flags;
  assign adv = !o_res_vld || i_rdy;
  assign o_rdy = adv;
  assign sa = i_a[W-1];
  assign sb = i_b[W-1] ^ i_sub;
  assign ea = i_a[W-2:MAN_W];
  assign eb = i_b[W-2:MAN_W];
  assign ma = i_a[MAN_W-1:0];
  assign mb = i_b[MAN_W-1:0];
  assign a_nan = &ea && |ma;
  assign b_nan = &eb && |mb;
  assign a_inf = &ea && !(|ma);
  assign b_inf = &eb && !(|mb);
  assign ea1 = |ea ? ea : EXP_W'(1);
  assign eb1 = |eb ? eb : EXP_W'(1);
  assign swap = {eb, mb} > {ea, ma};
  assign el = swap ? eb1 : ea1;
  assign d = swap ? eb1 - ea1 : ea1 - eb1;
  assign gl = swap ? {|eb, mb, 3'b0} : {|ea, ma, 3'b0};
  assign gx = swap ? {|ea, ma, 3'b0} : {|eb, mb, 3'b0};
  assign gmask = ~({GW{1'b1}} << d);
  // bits shifted past the sticky position are ORed back into it
  assign gs = (32'(d) >= 32'(MAN_W + 3)) ? {{(GW-1){1'b0}}, |gx}
            : (gx >> d) | {{(GW-1){1'b0}}, |(gx & gmask)};
  assign spc = a_nan | b_nan | a_inf | b_inf;
  assign spc_inv = (a_nan & !ma[MAN_W-1]) | (b_nan & !mb[MAN_W-1])
                 | (!a_nan & !b_nan & a_inf & b_inf & (sa ^ sb));
  assign spc_res = (a_nan | b_nan | (a_inf & b_inf & (sa ^ sb))) ? QNAN
                 : {a_inf ? sa : sb, EMAX, {MAN_W{1'b0}}};
  always_comb begin
    lz = SW'(GW);
    for (int i = 0; i < GW; i++)
      if (s2_sum[i]) lz = SW'(GW - 1 - i);
    e = XW'(s2_exp);
    sh = (XW'(lz) < e - XW'(1)) ? XW'(lz) : e - XW'(1);
    n = s2_sum[GW] ? {s2_sum[GW:2], |s2_sum[1:0]} : s2_sum[GW-1:0] << sh;
    en = s2_sum[GW] ? e + XW'(1) : e - sh;
    tiny = !n[GW-1];
    inx = |n[2:0];
`ifdef FP_ADDSUB_RNE_EN
    inc = n[2] & (n[1] | n[0] | n[3]);
    ovf_res = {s2_sgn, EMAX, {MAN_W{1'b0}}};
`else
    inc = 1'b0;
    ovf_res = {s2_sgn, EXP_W'(EMAX - 1), {MAN_W{1'b1}}};
`endif
    rnd = {1'b0, n[GW-1:3]} + (MAN_W+2)'(inc);
    ef = rnd[MAN_W+1] ? en + XW'(1) : en;
    ovf = ef >= XW'(EMAX);
    zs = s2_sub & !(|s2_sum);
    res = s2_spc ? s2_spc_res : ovf ? ovf_res
        : {s2_sgn & !zs, (rnd[MAN_W+1] | rnd[MAN_W]) ? ef[EXP_W-1:0] : EXP_W'(0),
           rnd[MAN_W+1] ? MAN_W'(0) : rnd[MAN_W-1:0]};
    flags = s2_spc ? {s2_spc_inv, 3'b000} : {1'b0, ovf, tiny & inx, inx | ovf};
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      o_res_vld <= 1'b0;
      o_res <= '0;
      o_tag <= '0;
      o_flags <= '0;
    end else if (adv) begin
      s1_vld <= i_vld;
      s2_vld <= s1_vld;
      o_res_vld <= s2_vld;
      if (s2_vld) begin
        o_res <= res;
        o_tag <= s2_tag;
        o_flags <= flags;
      end
    end
  always_ff @(posedge clk)
    if (adv) begin
      if (i_vld) begin
        s1_sgn <= swap ? sb : sa;
        s1_sub <= sa ^ sb;
        s1_exp <= el;
        s1_gl <= gl;
        s1_gs <= gs;
        s1_spc <= spc;
        s1_spc_res <= spc_res;
        s1_spc_inv <= spc_inv;
        s1_tag <= i_tag;
      end
      if (s1_vld) begin
        s2_sgn <= s1_sgn;
        s2_sub <= s1_sub;
        s2_exp <= s1_exp;
        s2_sum <= s1_sub ? {1'b0, s1_gl} - {1'b0, s1_gs} : {1'b0, s1_gl} + {1'b0, s1_gs};
        s2_spc <= s1_spc;
        s2_spc_res <= s1_spc_res;
        s2_spc_inv <= s1_spc_inv;
        s2_tag <= s1_tag;
      end
    end
endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, fully pipelined IEEE-754 floating-point adder/subtracter: the successor to the single-cycle single-precision add/sub block. It takes a runtime add/sub select and configurable exponent/mantissa widths, and keeps a 3-stage pipeline with valid/ready backpressure. A tag travels with each operation, and exception flags follow IEEE-754. It sits between the operand-issue logic and the result writeback in the FP datapath.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored mantissa width, hidden bit excluded (≥2)
- TAG_W, 4, width of the user tag carried alongside each operation
- W = 1+EXP_W+MAN_W, localparam, operand/result width

- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  synchronous, active-low reset
- i_a  in  W  operand A
- i_b  in  W  operand B
- i_sub  in  1  1: A−B, 0: A+B
- i_tag  in  TAG_W  user tag
- i_vld  in  1  input valid
- o_rdy  out  1  input ready
- o_res  out  W  result
- o_tag  out  TAG_W  tag of this result
- o_flags  out  4  {invalid, overflow, underflow, inexact}
- o_res_vld  out  1  result valid
- i_rdy  in  1  downstream ready

## Operation
- Effective sign of B is sign_b ^ i_sub.
- **Classification in S1.** exp==0 marks zero or subnormal: hidden bit 0, effective exponent 1. exp==all-ones marks Inf (mantissa 0) or NaN.
- **S1, unpack/align.** Swap so that |A| ≥ |B| by {exp, mantissa}. Right-shift the smaller significand by the exponent difference into MAN_W+1 bits plus guard/round/sticky. If the shift is ≥ MAN_W+3, all of B goes to sticky.
- **S2, add.** Compute (MAN_W+5)-bit add or subtract of the aligned significands. Result sign is the sign of the larger operand.
- **S3, normalise/round/pack.**
  - A carry-out shifts right by 1 and increments the exponent.
  - Otherwise, left-shift by the leading-zero count, limited so the exponent does not go below 1. A result that stays below 1 becomes subnormal (exp field 0).
  - Then round, renormalise on mantissa carry, and pack.
- **Special cases** are decided in S1 and carried down the pipe:
  - Any NaN input gives canonical qNaN {0, all-ones, 1, 0…}. invalid=1 only if an input is signalling (mantissa MSB 0).
  - Inf − Inf with effective opposite signs gives qNaN with invalid=1.
  - A single Inf, or like-signed Infs, pass through with the effective sign.
  - An exact-zero sum of opposite-signed operands gives +0. (+0)+(+0)=+0 and (−0)+(−0)=−0.
- **Overflow.** If the rounded exponent is ≥ all-ones, the result is signed Inf with overflow=1 and inexact=1.
- **Underflow.** underflow=1 when the result is tiny (before rounding) and inexact.
- **inexact** = any nonzero guard/round/sticky bits.

## Timing
- Latency is exactly 3 cycles from accept to o_res_vld when there is no stall.
- Throughput is 1 operation per cycle.
- **Accept.** An operation is accepted on a cycle with i_vld && o_rdy.
- **Global stall.** o_rdy = !o_res_vld || i_rdy. While i_rdy=0 and o_res_vld=1, every stage holds.
  - o_res, o_tag and o_flags stay stable until a cycle with i_rdy=1.
  - Pipeline bubbles, i.e. stages with valid=0, do not advance independently.
- Outputs change only after a handshake or a bubble advance.
- Results leave in order, each with its own tag.
- **Reset.** With rst_n=0 at a clock edge, all stage valids clear, o_res_vld=0, o_res=0, o_tag=0 and o_flags=0. Any in-flight operations are discarded.
- o_rdy is 1 on the first cycle after reset.
- o_rdy is combinational from i_rdy; this is the only combinational input-to-output path.

## Configuration
- FP_ADDSUB_RNE_EN defined: round-to-nearest, ties-to-even, using the guard/round/sticky bits.
- FP_ADDSUB_RNE_EN undefined: round toward zero (truncate). Overflow then gives the maximum finite value of the result's sign instead of Inf.
- inexact, overflow and underflow are still reported in both builds.

## Test plan
Values use the defaults EXP_W=8, MAN_W=23, with FP_ADDSUB_RNE_EN defined unless stated.
- 0x3F800000 + 0x40000000, i_sub=0, tag 5 → o_res_vld 3 cycles later with 0x40400000, tag 5, flags 0000.
- 0x40400000 − 0x40400000 (i_sub=1) → 0x00000000, flags 0000. 0x80000000 + 0x80000000 → 0x80000000.
- Rounding: 0x3F800001 + 0x33800000 (a tie) → 0x3F800002, inexact=1. In the FP_ADDSUB_RNE_EN-undefined build → 0x3F800001, inexact=1.
- Overflow and invalid:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 with overflow and inexact set (0x7F7FFFFF without RNE).
  - 0x7F800000 − 0x7F800000 → 0x7FC00000 with invalid=1.
  - 0x7F800001 + 1.0 → 0x7FC00000 with invalid=1.
- Subnormal: 0x00000001 + 0x00000001 → 0x00000002. 0x00800000 − 0x00000001 → 0x007FFFFF. Both with flags 0000.
- Backpressure and reset:
  - Issue 6 back-to-back ops with i_rdy held 0 for 4 cycles mid-stream → every op delivered once, in order, tags intact; o_rdy=0 while stalled with output valid.
  - rst_n pulsed low with 3 ops in flight → no results appear afterwards; o_res_vld=0 and o_rdy=1 on the next cycle.
